// File: rtl/pad_bank_ctrl.sv
// Pad-bank controller: drives pad-cell OEN/I/PEN/PUEN with per-pad direction turnaround,
// and returns each pad input through a 2-flop synchroniser and a glitch filter.
module pad_bank_ctrl #(
    parameter int NumPads      = 8,
    parameter int FilterCycles = 4,
    parameter int TurnCycles   = 2,
    localparam int IdxW        = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [IdxW-1:0]    cfg_idx_i,
    input  logic               cfg_oe_i,
    input  logic               cfg_pen_i,
    input  logic               cfg_pup_i,
    output logic               cfg_err_o,
    input  logic [NumPads-1:0] out_i,
    output logic [NumPads-1:0] pad_i_o,
    output logic [NumPads-1:0] pad_oen_o,
    output logic [NumPads-1:0] pad_pen_o,
    output logic [NumPads-1:0] pad_puen_o,
    input  logic [NumPads-1:0] pad_o_i,
    output logic [NumPads-1:0] in_o,
    output logic [NumPads-1:0] in_changed_o,
    output logic [NumPads-1:0] dir_busy_o
);

    localparam int TurnW = (TurnCycles > 0) ? $clog2(TurnCycles + 1) : 1;
    localparam int FiltW = (FilterCycles > 0) ? $clog2(FilterCycles + 1) : 1;
    localparam int CmpW  = IdxW + 1;
    localparam logic [TurnW-1:0] TurnLast = (TurnCycles > 0) ? TurnW'(TurnCycles - 1) : '0;
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FilterCycles);
    localparam logic [CmpW-1:0]  PadCount = CmpW'(NumPads);

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_OUT_TURN = 2'd1,
        ST_OUTPUT   = 2'd2,
        ST_IN_TURN  = 2'd3
    } dir_state_e;

    dir_state_e         state_q    [NumPads];
    dir_state_e         state_d    [NumPads];
    logic [TurnW-1:0]   turn_cnt_q [NumPads];
    logic [TurnW-1:0]   turn_cnt_d [NumPads];
    logic [NumPads-1:0] pen_q;
    logic [NumPads-1:0] pup_q;
    logic [NumPads-1:0] cfg_hit;
    logic [NumPads-1:0] busy;
    logic               cfg_ready;
    logic               cfg_fire;
    logic               idx_bad;
    logic               cfg_err_q;
    logic [NumPads-1:0] pad_i_q;

    assign idx_bad      = {1'b0, cfg_idx_i} >= PadCount;
    assign cfg_ready_o  = cfg_ready;
    assign dir_busy_o   = busy;
    assign cfg_err_o    = cfg_err_q;
    assign pad_i_o      = pad_i_q;

    // Direction FSM: next state and pad-cell control decode
    always_comb begin
        busy = '0;
        for (int p = 0; p < NumPads; p++) begin
            busy[p] = (state_q[p] == ST_OUT_TURN) || (state_q[p] == ST_IN_TURN);
        end
        cfg_ready  = ~|busy;
        cfg_fire   = cfg_valid_i & cfg_ready;
        cfg_hit    = '0;
        pad_oen_o  = '1;
        pad_pen_o  = '1;
        pad_puen_o = ~pup_q;
        for (int p = 0; p < NumPads; p++) begin
            state_d[p]    = state_q[p];
            turn_cnt_d[p] = '0;
            cfg_hit[p]    = cfg_fire && (cfg_idx_i == IdxW'(p));
            case (state_q[p])
                ST_INPUT: begin
                    pad_pen_o[p] = ~pen_q[p];
                    if (cfg_hit[p] && cfg_oe_i) begin
                        if (TurnCycles > 0) state_d[p] = ST_OUT_TURN;
                        else                state_d[p] = ST_OUTPUT;
                    end
                end
                ST_OUT_TURN: begin
                    if (turn_cnt_q[p] == TurnLast) state_d[p] = ST_OUTPUT;
                    else turn_cnt_d[p] = turn_cnt_q[p] + TurnW'(1);
                end
                ST_OUTPUT: begin
                    pad_oen_o[p] = 1'b0;
                    if (cfg_hit[p] && !cfg_oe_i) begin
                        if (TurnCycles > 0) state_d[p] = ST_IN_TURN;
                        else                state_d[p] = ST_INPUT;
                    end
                end
                ST_IN_TURN: begin
                    if (turn_cnt_q[p] == TurnLast) state_d[p] = ST_INPUT;
                    else turn_cnt_d[p] = turn_cnt_q[p] + TurnW'(1);
                end
                default: state_d[p] = ST_INPUT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPads; p++) begin
                state_q[p]    <= ST_INPUT;
                turn_cnt_q[p] <= '0;
            end
            pen_q     <= '1;
            pup_q     <= '0;
            cfg_err_q <= 1'b0;
            pad_i_q   <= '0;
        end else begin
            for (int p = 0; p < NumPads; p++) begin
                state_q[p]    <= state_d[p];
                turn_cnt_q[p] <= turn_cnt_d[p];
                if (cfg_hit[p]) begin
                    pen_q[p] <= cfg_pen_i;
                    pup_q[p] <= cfg_pup_i;
                end
            end
            cfg_err_q <= cfg_fire & idx_bad;
            pad_i_q   <= out_i;
        end
    end

    logic [NumPads-1:0] sync_p0;
    logic [NumPads-1:0] sync_p1;
    logic [NumPads-1:0] in_q;
    logic [NumPads-1:0] in_prev_q;
    logic [NumPads-1:0] chg_q;
    logic [FiltW-1:0]   filt_cnt_q [NumPads];

    assign in_o         = in_q;
    assign in_changed_o = chg_q;

    // Input path: sync_p0 -> sync_p1 -> glitch filter -> change detect
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            in_q      <= '0;
            in_prev_q <= '0;
            chg_q     <= '0;
            for (int p = 0; p < NumPads; p++) begin
                filt_cnt_q[p] <= '0;
            end
        end else begin
            sync_p0   <= pad_o_i;
            sync_p1   <= sync_p0;
            in_prev_q <= in_q;
            chg_q     <= in_q ^ in_prev_q;
            for (int p = 0; p < NumPads; p++) begin
                if (FilterCycles == 0) begin
                    in_q[p]       <= sync_p1[p];
                    filt_cnt_q[p] <= '0;
                end else if (sync_p1[p] == in_q[p]) begin
                    filt_cnt_q[p] <= '0;
                end else if (filt_cnt_q[p] + FiltW'(1) == FiltLast) begin
                    in_q[p]       <= sync_p1[p];
                    filt_cnt_q[p] <= '0;
                end else begin
                    filt_cnt_q[p] <= filt_cnt_q[p] + FiltW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Randomized and directed bench for pad_bank_ctrl against a cycle-level behavioural model.
module tb_pad_bank_ctrl;

    localparam int N    = 6;
    localparam int FILT = 4;
    localparam int TURN = 2;
    localparam int IW   = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [IW-1:0] cfg_idx_i;
    logic          cfg_oe_i;
    logic          cfg_pen_i;
    logic          cfg_pup_i;
    logic          cfg_err_o;
    logic [N-1:0]  out_i;
    logic [N-1:0]  pad_i_o;
    logic [N-1:0]  pad_oen_o;
    logic [N-1:0]  pad_pen_o;
    logic [N-1:0]  pad_puen_o;
    logic [N-1:0]  pad_o_i;
    logic [N-1:0]  in_o;
    logic [N-1:0]  in_changed_o;
    logic [N-1:0]  dir_busy_o;

    always #5 clk_i = ~clk_i;

    pad_bank_ctrl #(.NumPads(N), .FilterCycles(FILT), .TurnCycles(TURN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
        .cfg_oe_i(cfg_oe_i), .cfg_pen_i(cfg_pen_i), .cfg_pup_i(cfg_pup_i), .cfg_err_o(cfg_err_o),
        .out_i(out_i), .pad_i_o(pad_i_o), .pad_oen_o(pad_oen_o), .pad_pen_o(pad_pen_o),
        .pad_puen_o(pad_puen_o), .pad_o_i(pad_o_i), .in_o(in_o),
        .in_changed_o(in_changed_o), .dir_busy_o(dir_busy_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a pad is driving when its configured direction is output and no
    // turnaround is pending; in_o flips once FILT consecutive synchronised samples disagree.
    int           turn_left [N];
    logic [N-1:0] m_oe, m_pen, m_pup, m_pad_i, m_in, m_in_pp, m_chg;
    logic         m_err;
    logic [N-1:0] pad_q [$];
    logic [N-1:0] s_q [$];

    task automatic model_edge();
        logic [N-1:0] s;
        logic [N-1:0] new_in;
        bit           ready;
        bit           all_diff;
        int           idx;
        if (!rst_ni) begin
            for (int p = 0; p < N; p++) turn_left[p] = 0;
            m_oe = '0; m_pen = '1; m_pup = '0; m_pad_i = '0;
            m_in = '0; m_in_pp = '0; m_chg = '0; m_err = 1'b0;
            pad_q = {};
            pad_q.push_back('0);
            pad_q.push_back('0);
            s_q = {};
            return;
        end
        s = pad_q[pad_q.size() - 2];
        pad_q.push_back(pad_o_i);
        pad_q.pop_front();
        s_q.push_back(s);
        if (s_q.size() > FILT) s_q.pop_front();
        new_in = m_in;
        for (int p = 0; p < N; p++) begin
            if (FILT == 0) begin
                new_in[p] = s[p];
            end else if (s_q.size() == FILT) begin
                all_diff = 1'b1;
                foreach (s_q[i]) if (s_q[i][p] == m_in[p]) all_diff = 1'b0;
                if (all_diff) new_in[p] = s[p];
            end
        end
        m_chg   = m_in ^ m_in_pp;
        m_in_pp = m_in;
        m_in    = new_in;

        ready = 1'b1;
        for (int p = 0; p < N; p++) if (turn_left[p] != 0) ready = 1'b0;
        for (int p = 0; p < N; p++) if (turn_left[p] > 0) turn_left[p]--;
        m_err = 1'b0;
        if (cfg_valid_i && ready) begin
            idx = int'(cfg_idx_i);
            if (idx >= N) begin
                m_err = 1'b1;
            end else begin
                if (cfg_oe_i != m_oe[idx]) turn_left[idx] = TURN;
                m_oe[idx]  = cfg_oe_i;
                m_pen[idx] = cfg_pen_i;
                m_pup[idx] = cfg_pup_i;
            end
        end
        m_pad_i = out_i;
    endtask

    task automatic check_outputs();
        logic [N-1:0] busy, oen, pen, puen, overlap;
        for (int p = 0; p < N; p++) begin
            busy[p] = (turn_left[p] != 0);
            oen[p]  = busy[p] | ~m_oe[p];
            pen[p]  = busy[p] | m_oe[p] | ~m_pen[p];
            puen[p] = ~m_pup[p];
        end
        overlap = ~pad_oen_o & ~pad_pen_o;
        chk("pad_i", 32'(pad_i_o), 32'(m_pad_i));
        chk("pad_oen", 32'(pad_oen_o), 32'(oen));
        chk("pad_pen", 32'(pad_pen_o), 32'(pen));
        chk("pad_puen", 32'(pad_puen_o), 32'(puen));
        chk("dir_busy", 32'(dir_busy_o), 32'(busy));
        chk("cfg_ready", 32'(cfg_ready_o), 32'(~|busy));
        chk("cfg_err", 32'(cfg_err_o), 32'(m_err));
        chk("in", 32'(in_o), 32'(m_in));
        chk("in_changed", 32'(in_changed_o), 32'(m_chg));
        chk("drive_and_pull", 32'(overlap), 32'd0);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic cfg(input logic v, input int idx, input logic oe, input logic pen, input logic pup);
        cfg_valid_i = v;
        cfg_idx_i   = IW'(idx);
        cfg_oe_i    = oe;
        cfg_pen_i   = pen;
        cfg_pup_i   = pup;
    endtask

    initial begin
        rst_ni  = 1'b0;
        cfg(1'b0, 0, 1'b0, 1'b0, 1'b0);
        out_i   = '0;
        pad_o_i = '0;
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        chk("idle_oen", 32'(pad_oen_o), 32'h3F);
        chk("idle_pen", 32'(pad_pen_o), 32'h00);
        chk("idle_puen", 32'(pad_puen_o), 32'h3F);
        chk("idle_ready", 32'(cfg_ready_o), 32'd1);

        // pad 3 to output, then back to input with pull-up
        cfg(1'b1, 3, 1'b1, 1'b0, 1'b0);
        step();
        cfg_valid_i = 1'b0;
        chk("turn_busy3", 32'(dir_busy_o[3]), 32'd1);
        repeat (4) step();
        chk("out_oen3", 32'(pad_oen_o[3]), 32'd0);
        cfg(1'b1, 3, 1'b0, 1'b1, 1'b1);
        step();
        cfg_valid_i = 1'b0;
        chk("in_turn_oen3", 32'(pad_oen_o[3]), 32'd1);
        repeat (4) step();
        chk("pullup_pen3", 32'(pad_pen_o[3]), 32'd0);

        // 3-cycle glitch, then a stable rise on pad 0
        out_i = 6'h2A;
        pad_o_i[0] = 1'b1;
        repeat (3) step();
        pad_o_i[0] = 1'b0;
        repeat (8) step();
        chk("glitch_blocked", 32'(in_o[0]), 32'd0);
        pad_o_i[0] = 1'b1;
        repeat (5) step();
        chk("rise_early", 32'(in_o[0]), 32'd0);
        step();
        chk("rise_lat6", 32'(in_o[0]), 32'd1);
        step();
        chk("chg_pulse", 32'(in_changed_o[0]), 32'd1);
        step();
        chk("chg_single", 32'(in_changed_o[0]), 32'd0);

        // valid held through a turnaround
        cfg(1'b1, 1, 1'b1, 1'b1, 1'b0);
        step();
        chk("ready_low", 32'(cfg_ready_o), 32'd0);
        cfg(1'b1, 2, 1'b1, 1'b0, 1'b1);
        repeat (4) step();
        cfg_valid_i = 1'b0;
        repeat (3) step();

        // out-of-range index
        cfg(1'b1, 7, 1'b1, 1'b0, 1'b0);
        step();
        cfg_valid_i = 1'b0;
        chk("err_pulse", 32'(cfg_err_o), 32'd1);
        step();
        chk("err_clear", 32'(cfg_err_o), 32'd0);

        // reset during a turnaround
        cfg(1'b1, 4, 1'b1, 1'b0, 1'b0);
        step();
        cfg_valid_i = 1'b0;
        rst_ni = 1'b0;
        step();
        chk("rst_busy", 32'(dir_busy_o), 32'd0);
        chk("rst_oen", 32'(pad_oen_o), 32'h3F);
        rst_ni = 1'b1;
        step();

        for (int c = 0; c < 1500; c++) begin
            rst_ni      = ($urandom_range(0, 249) != 0);
            cfg_valid_i = ($urandom_range(0, 2) == 0);
            cfg_idx_i   = IW'($urandom_range(0, 7));
            cfg_oe_i    = 1'($urandom_range(0, 1));
            cfg_pen_i   = 1'($urandom_range(0, 1));
            cfg_pup_i   = 1'($urandom_range(0, 1));
            out_i       = N'($urandom);
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 7) == 0) pad_o_i[p] = ~pad_o_i[p];
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
